// File: rtl/multiport_memory.sv
`default_nettype none
// ============================================================================
// Module   : multiport_memory
// Brief    : Shared word array serving NUM_PORTS requesters through a
//            round-robin arbiter with a read/write/resp handshake.
// Revision : 1.0
// ============================================================================
module multiport_memory #(
    parameter int NUM_PORTS   = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_PORTS-1:0]                 read_i,
    input  logic [NUM_PORTS-1:0]                 write_i,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]  byte_enable_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      address_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]      wdata_i,
    output logic [NUM_PORTS-1:0]                 resp_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]      rdata_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int IDX   = $clog2(DEPTH_WORDS);
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW    = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                          state_q;
    logic [CW-1:0]                   cnt_q;
    logic [PW-1:0]                   last_q;
    logic [PW-1:0]                   gnt_q;
    logic [NUM_PORTS-1:0]            resp_q;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0]           mem_q [DEPTH_WORDS];

    logic [NUM_PORTS-1:0]  w_req;
    logic [BYTES-1:0]      w_be  [NUM_PORTS];
    logic [IDX-1:0]        w_idx [NUM_PORTS];
    logic [DATA_WIDTH-1:0] w_wd  [NUM_PORTS];
    logic                  w_found;
    logic [PW-1:0]         w_pick;
    logic [PW-1:0]         w_cand;
    logic [PW-1:0]         w_sel;
    logic                  w_enter;
    logic                  w_commit;
    logic                  w_unused;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign w_req[p] = read_i[p] | write_i[p];
        assign w_be[p]  = byte_enable_i[p*BYTES +: BYTES];
        assign w_idx[p] = address_i[p*ADDR_WIDTH + OFS +: IDX];
        assign w_wd[p]  = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
    end

    // Sub-word and wrap-around address bits are intentionally dropped.
    assign w_unused = ^address_i;

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_cand = PW'((int'(last_q) + k) % NUM_PORTS);
            if (!w_found && w_req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // The counter holds the cycles still to go before RESP, so RESP is
    // entered on the edge where it reaches 1 (or straight from IDLE when
    // LATENCY is 1), putting resp exactly LATENCY cycles after the grant.
    assign w_sel    = (state_q == S_IDLE) ? w_pick : gnt_q;
    assign w_enter  = ((state_q == S_IDLE) && w_found && (LATENCY == 1)) ||
                      ((state_q == S_BUSY) && w_req[gnt_q] && (cnt_q == CW'(1)));
    assign w_commit = (state_q == S_RESP) && write_i[gnt_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= PW'(NUM_PORTS - 1);
            gnt_q   <= '0;
            resp_q  <= '0;
            rdata_q <= '0;
        end else begin
            resp_q  <= '0;
            rdata_q <= '0;
            if (w_enter) begin
                resp_q[w_sel] <= 1'b1;
                if (!write_i[w_sel]) begin
                    rdata_q[w_sel*DATA_WIDTH +: DATA_WIDTH] <= mem_q[w_idx[w_sel]];
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (w_found) begin
                        last_q  <= w_pick;
                        gnt_q   <= w_pick;
                        cnt_q   <= CW'(LATENCY - 1);
                        state_q <= (LATENCY == 1) ? S_RESP : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!w_req[gnt_q]) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == CW'(1)) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Array is deliberately not reset; a reset mid-write leaves state IDLE
    // before the commit edge, so the word is untouched.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_be[gnt_q][b]) begin
                    mem_q[w_idx[gnt_q]][b*8 +: 8] <= w_wd[gnt_q][b*8 +: 8];
                end
            end
        end
    end

    assign resp_o  = resp_q;
    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_multiport_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiport_memory
// Brief    : Scoreboard bench for multiport_memory (LATENCY 4 and 1 builds).
// Revision : 1.0
// ============================================================================
module tb_multiport_memory;

    localparam int NP  = 2;
    localparam int DW  = 16;
    localparam int LAT = 4;

    typedef struct packed {
        logic        wr;
        logic [9:0]  idx;
        logic [15:0] d;
        logic [1:0]  be;
    } txn_t;

    logic clk;
    logic rst_n;
    int   cyc;

    logic [NP-1:0]    rd_v, wr_v;
    logic [NP*2-1:0]  be_v;
    logic [NP*16-1:0] addr_v;
    logic [NP*DW-1:0] wd_v;
    logic [NP-1:0]    resp;
    logic [NP*DW-1:0] rdata;

    logic        p_rd   [NP];
    logic        p_wr   [NP];
    logic [1:0]  p_be   [NP];
    logic [15:0] p_addr [NP];
    logic [15:0] p_wd   [NP];

    logic [1:0]  rd1, wr1, resp1;
    logic [3:0]  be1;
    logic [31:0] addr1, wd1, rdata1;

    logic [15:0] model [1024];
    txn_t        q0[$];
    txn_t        q1[$];
    int          order_q[$];
    int          n_vec;
    int          n_err;

    for (genvar p = 0; p < NP; p++) begin : g_pack
        assign rd_v[p]            = p_rd[p];
        assign wr_v[p]            = p_wr[p];
        assign be_v[p*2 +: 2]     = p_be[p];
        assign addr_v[p*16 +: 16] = p_addr[p];
        assign wd_v[p*DW +: DW]   = p_wd[p];
    end

    multiport_memory #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(16),
        .DEPTH_WORDS(1024), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .read_i(rd_v), .write_i(wr_v),
        .byte_enable_i(be_v), .address_i(addr_v), .wdata_i(wd_v),
        .resp_o(resp), .rdata_o(rdata)
    );

    multiport_memory #(
        .NUM_PORTS(2), .DATA_WIDTH(16), .ADDR_WIDTH(16),
        .DEPTH_WORDS(1024), .LATENCY(1)
    ) dut_l1 (
        .clk(clk), .rst_n(rst_n), .read_i(rd1), .write_i(wr1),
        .byte_enable_i(be1), .address_i(addr1), .wdata_i(wd1),
        .resp_o(resp1), .rdata_o(rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic monitor();
        txn_t        t;
        logic [15:0] d;
        forever begin
            @(negedge clk);
            if (rst_n && resp != '0) begin
                check("resp_onehot", 32'($countones(resp)), 32'd1);
                for (int p = 0; p < NP; p++) begin
                    d = rdata[p*DW +: DW];
                    if (!resp[p]) begin
                        check("idle_rdata", {16'd0, d}, 32'd0);
                    end else if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_resp: got resp on port %0d, expected none", p);
                    end else begin
                        if (p == 0) t = q0.pop_front();
                        else        t = q1.pop_front();
                        order_q.push_back(p);
                        if (!t.wr) begin
                            check("read_data", {16'd0, d}, {16'd0, model[t.idx]});
                        end else begin
                            for (int b = 0; b < 2; b++)
                                if (t.be[b]) model[t.idx][b*8 +: 8] = t.d[b*8 +: 8];
                        end
                    end
                end
            end
        end
    endtask

    // One handshake on port p; exp_lat < 0 means only the fairness bound applies.
    task automatic txn(input int p, input logic wr, input logic rd, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] be, input int exp_lat,
                       output logic [15:0] got);
        txn_t t;
        int   issue;
        bit   seen;
        @(posedge clk);
        #1;
        t.wr = wr; t.idx = a[10:1]; t.d = d; t.be = be;
        if (p == 0) q0.push_back(t);
        else        q1.push_back(t);
        p_rd[p] = rd; p_wr[p] = wr; p_addr[p] = a; p_wd[p] = d; p_be[p] = be;
        issue = cyc;
        seen  = 1'b0;
        got   = '0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (resp[p]) begin
                seen = 1'b1;
                got  = rdata[p*DW +: DW];
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL resp_timeout: got no resp on port %0d, expected one within 200 cycles", p);
        end else if (exp_lat >= 0) begin
            check("latency", cyc - issue, exp_lat);
        end else begin
            n_vec++;
            if (cyc - issue > NP * (LAT + 1) - 1) begin
                n_err++;
                $display("FAIL fairness: got latency %0d, expected <= %0d", cyc - issue, NP * (LAT + 1) - 1);
            end
        end
        @(posedge clk);
        #1;
        p_rd[p] = 1'b0; p_wr[p] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic rand_port(input int p);
        logic [15:0] g;
        logic        w;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            w = 1'($urandom_range(0, 1));
            txn(p, w, ~w, 16'($urandom), 16'($urandom), 2'($urandom), -1, g);
        end
    endtask

    initial begin
        logic [15:0] g;
        int          c0, prev, nseen;
        bit          seen;
        rst_n = 1'b0;
        for (int p = 0; p < NP; p++) begin
            p_rd[p] = 0; p_wr[p] = 0; p_be[p] = 0; p_addr[p] = 0; p_wd[p] = 0;
        end
        rd1 = 0; wr1 = 0; be1 = 0; addr1 = 0; wd1 = 0;
        repeat (2) @(negedge clk);
        check("reset_resp", {30'd0, resp}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_resp_l1", {30'd0, resp1}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        fork monitor(); join_none

        for (int i = 0; i < 1024; i++)
            txn(0, 1'b1, 1'b0, 16'(i * 2), (i == 16) ? 16'hBEEF : 16'($urandom), 2'b11, -1, g);

        // Single read with fixed latency, then byte-lane write.
        txn(0, 1'b0, 1'b1, 16'h0020, 16'h0, 2'b00, 4, g);
        check("single_read", {16'd0, g}, 32'h0000BEEF);
        txn(1, 1'b1, 1'b0, 16'h0020, 16'h1234, 2'b01, 4, g);
        txn(0, 1'b0, 1'b1, 16'h0020, 16'h0, 2'b00, 4, g);
        check("byte_enable", {16'd0, g}, 32'h0000BE34);

        // Address wrap and read+write treated as write.
        txn(0, 1'b1, 1'b0, 16'h0802, 16'hAAAA, 2'b11, 4, g);
        txn(1, 1'b0, 1'b1, 16'h0002, 16'h0, 2'b00, 4, g);
        check("wrap", {16'd0, g}, 32'h0000AAAA);
        txn(1, 1'b1, 1'b1, 16'h0004, 16'h5555, 2'b11, 4, g);
        txn(0, 1'b0, 1'b1, 16'h0004, 16'h0, 2'b00, 4, g);
        check("rw_is_write", {16'd0, g}, 32'h00005555);

        // Simultaneous reads right after reset.
        pulse_reset();
        fork
            begin logic [15:0] g0; txn(0, 1'b0, 1'b1, 16'h0010, 16'h0, 2'b00, 4, g0); end
            begin logic [15:0] g1; txn(1, 1'b0, 1'b1, 16'h0012, 16'h0, 2'b00, 9, g1); end
        join

        // Continuous requests on both ports must alternate.
        order_q.delete();
        fork
            begin logic [15:0] ga; for (int i = 0; i < 3; i++) txn(0, 1'b0, 1'b1, 16'h0100, 16'h0, 2'b00, -1, ga); end
            begin logic [15:0] gb; for (int i = 0; i < 3; i++) txn(1, 1'b0, 1'b1, 16'h0200, 16'h0, 2'b00, -1, gb); end
        join
        check("alt_count", order_q.size(), 32'd6);
        for (int i = 0; i < 6 && i < order_q.size(); i++)
            check("alternation", order_q[i], i % 2);

        // Port 0 aborts in BUSY; port 1 is granted next.
        pulse_reset();
        fork
            begin
                @(posedge clk); #1;
                p_rd[0] = 1'b1; p_addr[0] = 16'h0030;
                repeat (2) @(posedge clk);
                #1; p_rd[0] = 1'b0;
            end
            begin logic [15:0] g2; txn(1, 1'b0, 1'b1, 16'h0032, 16'h0, 2'b00, 7, g2); end
        join

        // Reset during a write's BUSY must not commit it.
        @(posedge clk); #1;
        p_wr[0] = 1'b1; p_addr[0] = 16'h0006; p_wd[0] = 16'hDEAD; p_be[0] = 2'b11;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b0; p_wr[0] = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        txn(1, 1'b0, 1'b1, 16'h0006, 16'h0, 2'b00, 4, g);

        fork
            rand_port(0);
            rand_port(1);
        join

        // LATENCY=1 build: one-cycle latency and back-to-back reads.
        @(posedge clk); #1;
        wr1 = 2'b01; addr1 = 32'h0000_0040; wd1 = 32'h0000_1357; be1 = 4'b0011;
        c0 = cyc; seen = 1'b0; prev = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (resp1[0]) begin seen = 1'b1; prev = cyc; end
        end
        check("l1_write_lat", seen ? prev - c0 : -1, 32'd1);
        @(posedge clk); #1; wr1 = 2'b00;
        @(posedge clk); #1;
        rd1 = 2'b01; c0 = cyc; prev = c0; nseen = 0;
        for (int k = 0; k < 20 && nseen < 3; k++) begin
            @(negedge clk);
            if (resp1[0]) begin
                check("l1_gap", cyc - prev, (nseen == 0) ? 1 : 2);
                check("l1_rdata", rdata1[15:0], 32'h0000_1357);
                prev = cyc;
                nseen++;
            end
        end
        check("l1_count", nseen, 32'd3);
        @(posedge clk); #1; rd1 = 2'b00;

        repeat (4) @(posedge clk);
        check("sb_drain", q0.size() + q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
